// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- hazard detection and forwarding control for a
// five-stage pipeline that also has a single multicycle execution unit.
//
// Ports
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   id_valid, flush              : ID holds an instruction / that instruction is killed
//   id_rs, id_rt, id_use_rs/rt   : source registers and whether they are read
//   id_wreg, id_m2reg, id_mc     : writes a register / is a load / is a multicycle op
//   id_rn                        : destination register
//   fwda, fwdb                   : operand source: 00 regfile, 01 E ALU, 10 M ALU, 11 M memory
//   nostall                      : ID may advance this cycle
//   e_*, m_*                     : destination tracking for the E and M stages
//   mc_busy, mc_done, mc_rn      : multicycle unit status and its destination
module pipe_hazard_ctrl #(
  parameter int RW    = 5,
  parameter int MCLAT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_mc,
  input  logic [RW-1:0] id_rn,
  input  logic          flush,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          nostall,
  output logic          e_wreg,
  output logic          e_m2reg,
  output logic          m_wreg,
  output logic          m_m2reg,
  output logic [RW-1:0] e_rn,
  output logic [RW-1:0] m_rn,
  output logic          mc_busy,
  output logic          mc_done,
  output logic [RW-1:0] mc_rn
);

  localparam int            CW      = $clog2(MCLAT + 1);
  localparam logic [CW-1:0] MC_LOAD = CW'(MCLAT);

  logic [CW-1:0] mc_cnt_reg;
  logic          issue;
  logic          load_use;
  logic          mc_dep;
  logic          mc_struct;

  // Remaining cycles of the multicycle op; zero means the unit is idle.
  assign mc_busy = (mc_cnt_reg != '0);
  assign mc_done = (mc_cnt_reg == CW'(1));

  // Hazard detection. Register 0 is hardwired, so it never creates a hazard.
  always_comb begin
    load_use  = 1'b0;
    mc_dep    = 1'b0;
    mc_struct = 1'b0;
    nostall   = 1'b1;

    load_use = e_wreg && e_m2reg && (e_rn != '0) &&
               ((id_use_rs && (e_rn == id_rs)) || (id_use_rt && (e_rn == id_rt)));

    // Destination match is included so a younger write cannot land before
    // the multicycle result and then be overwritten by it.
    mc_dep = mc_busy && (mc_rn != '0) &&
             ((id_use_rs && (id_rs == mc_rn)) ||
              (id_use_rt && (id_rt == mc_rn)) ||
              (id_wreg   && (id_rn == mc_rn)));

    // Only one multicycle op can be in flight.
    mc_struct = mc_busy && id_mc;

    // A flushed instruction is discarded, so it never needs to wait.
    if (id_valid && !flush && (load_use || mc_dep || mc_struct))
      nostall = 1'b0;
  end

  assign issue = id_valid && !flush && nostall;

  // Forwarding select, one copy per source operand. The E stage is the
  // youngest producer, so it wins over M. A load still in E cannot be
  // forwarded (that case stalls instead).
  logic [RW-1:0] src_rn  [2];
  logic          src_use [2];
  logic [1:0]    fwd_sel [2];

  assign src_rn[0]  = id_rs;
  assign src_rn[1]  = id_rt;
  assign src_use[0] = id_use_rs;
  assign src_use[1] = id_use_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
        !src_use[gi]                                                        ? 2'b00 :
        (e_wreg && !e_m2reg && (e_rn != '0) && (e_rn == src_rn[gi]))        ? 2'b01 :
        (m_wreg && !m_m2reg && (m_rn != '0) && (m_rn == src_rn[gi]))        ? 2'b10 :
        (m_wreg &&  m_m2reg && (m_rn != '0) && (m_rn == src_rn[gi]))        ? 2'b11 :
                                                                              2'b00;
    end
  endgenerate

  assign fwda = fwd_sel[0];
  assign fwdb = fwd_sel[1];

  // E/M tracking. Multicycle ops bypass E (their result is tracked by the
  // counter), so they and all non-issuing cycles enter E as bubbles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_rn    <= '0;
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
      m_rn    <= '0;
    end else begin
      if (issue && !id_mc) begin
        e_wreg  <= id_wreg;
        e_m2reg <= id_m2reg;
        e_rn    <= id_rn;
      end else begin
        e_wreg  <= 1'b0;
        e_m2reg <= 1'b0;
        e_rn    <= '0;
      end
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_rn    <= e_rn;
    end
  end

  // Multicycle countdown. A new op cannot issue while busy (structural
  // stall), so the load and the decrement never compete.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mc_cnt_reg <= '0;
      mc_rn      <= '0;
    end else begin
      if (issue && id_mc) begin
        mc_cnt_reg <= MC_LOAD;
        mc_rn      <= id_rn;
      end else if (mc_cnt_reg != '0) begin
        mc_cnt_reg <= mc_cnt_reg - CW'(1);
      end
    end
  end

endmodule
